// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and encodings for the LFSR sample generator
//
// Purpose: holds the MODE encodings, the generator FSM state type and the
// default 8-bit tap mask / seed used by lfsr_gen and lfsr_next.
// Ports: none (package).

package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_HOLD = 1'b1
    } lfsr_state_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational one-step LFSR next-state function
//
// Purpose: computes the state that follows st for either a Fibonacci
// (TAPS is the feedback tap mask) or a Galois (TAPS is the polynomial
// without the x^WIDTH term) register.
// Ports:
//   st      in  WIDTH  current state
//   st_next out WIDTH  state after one advance

module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter int               MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] st,
    output logic [WIDTH-1:0] st_next
);

    generate
        if (MODE == MODE_GAL) begin : g_galois
            // Shift toward the MSB; the bit falling out selects the polynomial.
            always_comb begin
                st_next = {st[WIDTH-2:0], 1'b0} ^ (st[WIDTH-1] ? TAPS : '0);
            end
        end else begin : g_fibonacci
            // Parity of the tapped bits is shifted in at the LSB.
            always_comb begin
                st_next = {st[WIDTH-2:0], ^(st & TAPS)};
            end
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR pseudo-random sample generator with valid/ready output
//
// Purpose: advances an LFSR STEPS times per sample while en is high, then
// presents the new state on rnd with rnd_valid until rd_ready accepts it.
// load reseeds at any time; a zero seed is replaced by SEED and flagged.
// Optional build macro: LFSR_GEN_STATS_EN adds the draw_count transfer counter.
// Ports:
//   Clk        in  1      clock
//   rst        in  1      asynchronous active-high reset
//   en         in  1      advance enable
//   load       in  1      synchronous seed load strobe
//   seed_in    in  WIDTH  seed value
//   rd_ready   in  1      consumer accepts sample
//   rnd        out WIDTH  registered sample
//   rnd_valid  out 1      sample available
//   zero_fix   out 1      one-cycle pulse when a zero seed was replaced
//   draw_count out 16     completed transfers (LFSR_GEN_STATS_EN only)

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter int               STEPS = 1,
    parameter int               MODE  = MODE_FIB
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             zero_fix
`ifdef LFSR_GEN_STATS_EN
    ,
    output logic [15:0]      draw_count
`endif
);

    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] st_nxt;
    logic [7:0]       cnt;
    lfsr_state_t      state;
    logic             last_step;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .st      (st),
        .st_next (st_nxt)
    );

    // cnt counts advances already done for the sample in progress.
    assign last_step = (cnt == 8'(STEPS - 1));

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            st        <= SEED;
            cnt       <= '0;
            state     <= ST_STEP;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            zero_fix  <= 1'b0;
        end else begin
            zero_fix <= 1'b0;
            if (load) begin
                // A zero state would lock the LFSR, so fall back to SEED.
                if (seed_in == '0) begin
                    st       <= SEED;
                    zero_fix <= 1'b1;
                end else begin
                    st <= seed_in;
                end
                cnt       <= '0;
                rnd_valid <= 1'b0;
                state     <= ST_STEP;
            end else begin
                case (state)
                    ST_STEP: begin
                        if (en) begin
                            st <= st_nxt;
                            if (last_step) begin
                                rnd       <= st_nxt;
                                rnd_valid <= 1'b1;
                                cnt       <= '0;
                                state     <= ST_HOLD;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // rnd keeps the accepted value after the handshake.
                        if (rd_ready) begin
                            rnd_valid <= 1'b0;
                            state     <= ST_STEP;
                        end
                    end
                    default: state <= ST_STEP;
                endcase
            end
        end
    end

`ifdef LFSR_GEN_STATS_EN
    // A handshake coinciding with load still counts as a completed draw;
    // only reset clears the counter.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            draw_count <= '0;
        end else if (rnd_valid && rd_ready) begin
            draw_count <= draw_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen (table, corner sequences, random vs model)

module tb_lfsr_gen;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst;
    logic       en0, load0, rdy0, v0, zf0;
    logic [7:0] seed0, rnd0;
    logic       en1, load1, rdy1, v1, zf1;
    logic [7:0] seed1, rnd1;
    logic       en2, load2, rdy2, v2, zf2;
    logic [3:0] seed2, rnd2;
`ifdef LFSR_GEN_STATS_EN
    logic [15:0] dc0, dc1, dc2;
`endif

    lfsr_gen dut0 (
        .Clk(Clk), .rst(rst), .en(en0), .load(load0), .seed_in(seed0),
        .rd_ready(rdy0), .rnd(rnd0), .rnd_valid(v0), .zero_fix(zf0)
`ifdef LFSR_GEN_STATS_EN
        , .draw_count(dc0)
`endif
    );

    lfsr_gen #(.STEPS(3)) dut1 (
        .Clk(Clk), .rst(rst), .en(en1), .load(load1), .seed_in(seed1),
        .rd_ready(rdy1), .rnd(rnd1), .rnd_valid(v1), .zero_fix(zf1)
`ifdef LFSR_GEN_STATS_EN
        , .draw_count(dc1)
`endif
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1)) dut2 (
        .Clk(Clk), .rst(rst), .en(en2), .load(load2), .seed_in(seed2),
        .rd_ready(rdy2), .rnd(rnd2), .rnd_valid(v2), .zero_fix(zf2)
`ifdef LFSR_GEN_STATS_EN
        , .draw_count(dc2)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_all();
        en0 = 0; load0 = 0; rdy0 = 0; seed0 = '0;
        en1 = 0; load1 = 0; rdy1 = 0; seed1 = '0;
        en2 = 0; load2 = 0; rdy2 = 0; seed2 = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        #2;
        @(posedge Clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int w; int taps; int seed; int steps; bit gal;
    } cfg_t;

    typedef struct {
        int st; int n; int rnd; bit v; bit zf; int draws;
    } mdl_t;

    function automatic int adv(cfg_t c, int s);
        int mask;
        int r;
        mask = (1 << c.w) - 1;
        if (c.gal) begin
            r = (s * 2) & mask;
            if (s >= (1 << (c.w - 1))) r = r ^ c.taps;
        end else begin
            r = ((s * 2) + ($countones(s & c.taps) % 2)) & mask;
        end
        return r;
    endfunction

    function automatic mdl_t mreset(cfg_t c);
        mdl_t m;
        m.st = c.seed; m.n = 0; m.rnd = 0; m.v = 0; m.zf = 0; m.draws = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(cfg_t c, mdl_t mi, bit en, bit ld, int sd, bit rdy);
        mdl_t m;
        m = mi;
        m.zf = 0;
        if (m.v && rdy) m.draws = (m.draws + 1) % 65536;
        if (ld) begin
            m.st = (sd == 0) ? c.seed : sd;
            m.zf = (sd == 0);
            m.n  = 0;
            m.v  = 0;
        end else if (m.v) begin
            if (rdy) m.v = 0;
        end else if (en) begin
            m.st = adv(c, m.st);
            m.n++;
            if (m.n == c.steps) begin
                m.rnd = m.st;
                m.v   = 1;
                m.n   = 0;
            end
        end
        return m;
    endfunction

    // ---------------- directed table for dut0 ----------------
    typedef struct {
        logic       en;
        logic       load;
        logic [7:0] seed;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_rnd;
        logic       exp_zf;
    } vec_t;

    vec_t tbl[12];
    logic [3:0] gal_exp[15];

    initial begin
        cfg_t c0, c1, c2;
        mdl_t m0, m1, m2;
        int   t;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h4A, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h4A, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h95, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h95, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h95, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h95, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h95, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h95, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h4A, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'h4A, 1'b1, 1'b0, 8'h4A, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h95, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h95, 1'b0};

        gal_exp = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                    4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

        // Reset state, observed while reset is still asserted.
        idle_all();
        rst = 1'b1;
        #12;
        chk("reset_rnd0", rnd0, 0);
        chk("reset_valid0", v0, 0);
        chk("reset_zf0", zf0, 0);
        chk("reset_valid1", v1, 0);
        chk("reset_rnd2", rnd2, 0);
        chk("reset_valid2", v2, 0);
`ifdef LFSR_GEN_STATS_EN
        chk("reset_draw_count", dc0, 0);
`endif
        @(posedge Clk);
        #1;
        rst = 1'b0;

        // Directed table on the default instance.
        for (int i = 0; i < 12; i++) begin
            en0 = tbl[i].en; load0 = tbl[i].load; seed0 = tbl[i].seed; rdy0 = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_valid", i), v0, tbl[i].exp_v);
            chk($sformatf("tbl%0d_rnd", i), rnd0, tbl[i].exp_rnd);
            chk($sformatf("tbl%0d_zero_fix", i), zf0, tbl[i].exp_zf);
        end

        // Hold for 10 cycles with rd_ready low, en toggling randomly.
        do_reset();
        en0 = 1; rdy0 = 0;
        tick();
        chk("hold_first_valid", v0, 1);
        chk("hold_first_rnd", rnd0, 8'h4A);
        for (int i = 0; i < 10; i++) begin
            en0 = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("hold%0d_valid", i), v0, 1);
            chk($sformatf("hold%0d_rnd", i), rnd0, 8'h4A);
        end
        en0 = 1; rdy0 = 1;
        tick();
        chk("hold_release_valid", v0, 0);
        chk("hold_release_rnd_kept", rnd0, 8'h4A);
        rdy0 = 0;
        tick();
        chk("hold_next_valid", v0, 1);
        chk("hold_next_rnd", rnd0, 8'h95);

        // Reset asserted mid-HOLD between edges discards the sample at once.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", v0, 0);
        chk("async_rst_rnd", rnd0, 0);
        @(posedge Clk);
        #1;
        rst = 1'b0;

        // STEPS=3: three enabled cycles (with one disabled gap) before a sample.
        idle_all();
        rdy1 = 0;
        en1 = 1; tick(); chk("steps3_c1_valid", v1, 0);
        en1 = 0; tick(); chk("steps3_gap_valid", v1, 0);
        en1 = 1; tick(); chk("steps3_c2_valid", v1, 0);
        en1 = 1; tick(); chk("steps3_c3_valid", v1, 1);
        chk("steps3_rnd", rnd1, 8'h2A);

        // Mid-STEP zero-seed load on STEPS=3: pulse is one cycle, latency restarts.
        do_reset();
        en1 = 1; tick();
        load1 = 1; seed1 = 8'h00; tick();
        chk("steps3_zf_pulse", zf1, 1);
        chk("steps3_load_valid", v1, 0);
        load1 = 0; tick();
        chk("steps3_zf_drop", zf1, 0);
        tick();
        chk("steps3_reload_c2_valid", v1, 0);
        tick();
        chk("steps3_reload_valid", v1, 1);
        chk("steps3_reload_rnd", rnd1, 8'h2A);

        // Galois WIDTH=4 continuous draw, 15 samples covering the full period.
        do_reset();
        en2 = 1; rdy2 = 1;
        for (int k = 0; k < 15; k++) begin
            t = 0;
            while (!v2 && t < 10) begin
                tick();
                t++;
            end
            chk($sformatf("gal_s%0d_valid", k), v2, 1);
            chk($sformatf("gal_s%0d_rnd", k), rnd2, gal_exp[k]);
            tick();
        end

`ifdef LFSR_GEN_STATS_EN
        // Transfer counter survives load, cleared by reset.
        do_reset();
        en0 = 1; rdy0 = 1;
        repeat (10) tick();
        en0 = 0; rdy0 = 0;
        tick();
        chk("stats_after_5", dc0, 5);
        load0 = 1; seed0 = 8'h33; tick(); load0 = 0;
        chk("stats_after_load", dc0, 5);
        rst = 1; #1;
        chk("stats_after_rst", dc0, 0);
        @(posedge Clk); #1; rst = 0;
`endif

        // Randomized run of all three instances against the reference model.
        c0 = '{8, 'hB8, 'hA5, 1, 1'b0};
        c1 = '{8, 'hB8, 'hA5, 3, 1'b0};
        c2 = '{4, 'h3, 'h1, 1, 1'b1};
        do_reset();
        m0 = mreset(c0);
        m1 = mreset(c1);
        m2 = mreset(c2);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            en0 = ($urandom_range(0, 3) != 0);
            rdy0 = 1'($urandom_range(0, 1));
            load0 = ($urandom_range(0, 19) == 0);
            seed0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            en1 = ($urandom_range(0, 3) != 0);
            rdy1 = 1'($urandom_range(0, 1));
            load1 = ($urandom_range(0, 19) == 0);
            seed1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            en2 = ($urandom_range(0, 3) != 0);
            rdy2 = 1'($urandom_range(0, 1));
            load2 = ($urandom_range(0, 19) == 0);
            seed2 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            m0 = mstep(c0, m0, en0, load0, int'(seed0), rdy0);
            m1 = mstep(c1, m1, en1, load1, int'(seed1), rdy1);
            m2 = mstep(c2, m2, en2, load2, int'(seed2), rdy2);
            tick();
            chk($sformatf("rand%0d_rnd0", cyc), rnd0, m0.rnd);
            chk($sformatf("rand%0d_valid0", cyc), v0, m0.v);
            chk($sformatf("rand%0d_zf0", cyc), zf0, m0.zf);
            chk($sformatf("rand%0d_rnd1", cyc), rnd1, m1.rnd);
            chk($sformatf("rand%0d_valid1", cyc), v1, m1.v);
            chk($sformatf("rand%0d_zf1", cyc), zf1, m1.zf);
            chk($sformatf("rand%0d_rnd2", cyc), rnd2, m2.rnd);
            chk($sformatf("rand%0d_valid2", cyc), v2, m2.v);
            chk($sformatf("rand%0d_zf2", cyc), zf2, m2.zf);
`ifdef LFSR_GEN_STATS_EN
            chk($sformatf("rand%0d_dc0", cyc), dc0, m0.draws);
            chk($sformatf("rand%0d_dc1", cyc), dc1, m1.draws);
            chk($sformatf("rand%0d_dc2", cyc), dc2, m2.draws);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- WIDTH, 8, state/output width, legal 4..32.
- TAPS, 8'hB8, WIDTH-bit tap mask (Fibonacci) or polynomial (Galois, bit0 SHALL be 1).
- SEED, 8'hA5, reset/fallback state, SHALL be non-zero.
- STEPS, 1, LFSR advances per delivered sample, legal 1..255.
- MODE, 0, 0 = Fibonacci, 1 = Galois.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- Clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- en, in, 1, advance enable.
- load, in, 1, synchronous seed load strobe.
- seed_in, in, WIDTH, seed value.
- rd_ready, in, 1, consumer accepts sample.
- rnd, out, WIDTH, registered sample.
- rnd_valid, out, 1, sample available.
- zero_fix, out, 1, one-cycle pulse when a zero seed was replaced.
- draw_count, out, 16, completed transfers; present only under LFSR_GEN_STATS_EN.

Function
REQ-003 Fibonacci advance SHALL be st <= {st[WIDTH-2:0], ^(st & TAPS)}.
REQ-004 Galois advance SHALL be st <= {st[WIDTH-2:0],1'b0} ^ (st[WIDTH-1] ? TAPS : 0).
REQ-005 The FSM SHALL have two states: STEP (advancing) and HOLD (sample presented).
REQ-006 In STEP with en=1, st SHALL advance once per cycle and step counter cnt SHALL increment. With en=0, st and cnt SHALL freeze.
REQ-007 On the edge performing the STEPS-th advance, rnd SHALL take the new st, rnd_valid SHALL go 1, cnt SHALL clear, and the FSM SHALL enter HOLD.
REQ-008 In HOLD, st, rnd and rnd_valid SHALL be stable regardless of en until rd_ready=1.
REQ-009 When rnd_valid and rd_ready are both 1, the transfer SHALL complete that edge: rnd_valid goes 0 and the FSM returns to STEP. rnd SHALL keep its last value.
REQ-010 A load in any state SHALL set st <= seed_in, cnt <= 0, rnd_valid <= 0 and FSM <= STEP. load SHALL take priority over en/advance.
REQ-011 If load and a transfer coincide, the transfer SHALL count as completed and load SHALL apply.
REQ-012 If seed_in == 0 on load, st SHALL take SEED and zero_fix SHALL pulse high for exactly one cycle; otherwise zero_fix SHALL be 0.
REQ-013 Sample latency from reset release or load SHALL be STEPS enabled cycles.

Reset
REQ-014 On rst: st = SEED, cnt = 0, FSM = STEP, rnd = 0, rnd_valid = 0, zero_fix = 0, draw_count = 0.
REQ-015 rst asserted mid-STEP or mid-HOLD SHALL discard any pending sample immediately.

Configuration
REQ-016 With LFSR_GEN_STATS_EN defined, draw_count SHALL increment, wrapping at 16 bits, on every completed transfer. It SHALL be cleared by rst only, not by load.
REQ-017 Without LFSR_GEN_STATS_EN, the draw_count port and its counter SHALL be absent.

Structure
REQ-018 A shared package lfsr_pkg SHALL hold the MODE encodings (MODE_FIB = 0, MODE_GAL = 1), the FSM state encoding and the default TAPS/SEED constants.
REQ-019 The next-state function SHALL be a combinational sub-module lfsr_next (params WIDTH, TAPS, MODE). The FSM, counter and handshake SHALL stay in lfsr_gen.

Verification
REQ-020 Defaults, en=1, rd_ready=1 after reset -> rnd sequence 0x4A, 0x95 on successive samples, each valid 1 cycle after its advance.
REQ-021 STEPS=3, defaults, en=1 -> first sample rnd=0x2A after 3 enabled cycles, rnd_valid low before that.
REQ-022 First sample valid (0x4A), rd_ready=0 for 10 cycles -> rnd=0x4A and rnd_valid=1 held throughout; rd_ready=1 -> next sample 0x95.
REQ-023 load with seed_in=0x00 mid-STEP -> zero_fix one-cycle pulse, st=0xA5, next sample 0x4A; load with seed_in=0x4A -> next sample 0x95.
REQ-024 WIDTH=4, MODE=1, TAPS=4'h3, SEED=4'h1, continuous draw -> rnd 2, 4, 8, 3, ...; the 15th sample equals 1.
REQ-025 LFSR_GEN_STATS_EN defined, 5 transfers, then load, then rst -> draw_count 5 after the transfers, still 5 after load, 0 after rst.
